adder_rr_sched: RTL and testbench

- Round-robin scheduler that shares one registered W-bit adder among NREQ requesters.
- Each requester presents an operand pair under a valid/ready handshake. One pair is granted per cycle.
- The sum, the carry and the requester ID are returned on a single valid/ready result port.
- Sits between the pin-level input muxing and the output drivers of the demo top. It lets several operand sources time-share the existing adder datapath.

---
 rtl/adder_sched_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/adder_rr_sched.sv | 93 +++++++++
 tb/tb_adder_rr_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared constants, id-width helper and result FSM states for adder_rr_sched
package adder_sched_pkg;

    localparam int DEF_W    = 8;
    localparam int DEF_NREQ = 4;

    // A single requester still needs a 1-bit id field, so never return zero.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: first requester at or after ptr, one-hot plus encoded grant
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        // Walk ptr, ptr+1, ... with wrap; the first hit wins.
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_rr_sched.sv
// rtl/adder_rr_sched.sv - round-robin shared registered adder; ADDER_SCHED_SAT_EN enables saturating sum
module adder_rr_sched
    import adder_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int W    = DEF_W,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_sum,
    output logic              res_carry,
    output logic [IDW-1:0]    res_id
);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic           can_accept;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] grant_idx;
    logic           fire;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W:0]     sum_full;
    logic [W-1:0]   sum_next;
    logic [IDW-1:0] ptr_next;

    // A pending result blocks new grants unless it is consumed this same edge.
    assign can_accept = (state == EMPTY) || res_ready;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .enable    (can_accept),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign fire      = |grant;

    assign a_sel    = req_a[int'(grant_idx)*W +: W];
    assign b_sel    = req_b[int'(grant_idx)*W +: W];
    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef ADDER_SCHED_SAT_EN
    assign sum_next = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
    assign sum_next = sum_full[W-1:0];
`endif

    assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            ptr       <= '0;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (fire) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (res_ready && !fire) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            // Output fields only move on a transfer; a bare consume leaves them as they were.
            if (fire) begin
                res_sum   <= sum_next;
                res_carry <= sum_full[W];
                res_id    <= grant_idx;
                ptr       <= ptr_next;
            end
        end
    end

    assign res_valid = (state == FULL);

endmodule

// File: tb/tb_adder_rr_sched.sv
// tb/tb_adder_rr_sched.sv - self-checking bench for adder_rr_sched (vectors, corner sequences, random vs model)
module tb_adder_rr_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

`ifdef ADDER_SCHED_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_carry;
    logic [IDW-1:0]    res_id;

    adder_rr_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int       id;
        bit [7:0] a;
        bit [7:0] b;
        bit [7:0] exp_sum;
        bit       exp_carry;
    } vec_t;

    vec_t vecs[6];

    // Reference model state
    int       mptr;
    bit       mfull;
    bit [7:0] msum;
    bit       mcarry;
    int       mid;
    bit       vv[NREQ];
    int       wait_x[NREQ];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit [8:0] ref_add(input bit [7:0] a, input bit [7:0] b);
        int s;
        s = int'(a) + int'(b);
        if (s >= 256) return {1'b1, SAT ? 8'hFF : 8'(s - 256)};
        return {1'b0, 8'(s)};
    endfunction

    task automatic set_op(input int i, input bit [7:0] a, input bit [7:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One cycle against the model: check grant, clock, check result register.
    task automatic model_cycle(output int g);
        bit [8:0] r;
        g = -1;
        #1;
        if (!mfull || res_ready) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
            end
        end
        chk("rand_req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        @(posedge clk);
        if (g >= 0) begin
            r      = ref_add(req_a[g*W +: W], req_b[g*W +: W]);
            mcarry = r[8];
            msum   = r[7:0];
            mid    = g;
            mfull  = 1'b1;
            mptr   = (g + 1) % NREQ;
        end else if (mfull && res_ready) begin
            mfull = 1'b0;
        end
        #1;
        chk("rand_res_valid", 32'(res_valid), 32'(mfull));
        if (mfull) begin
            chk("rand_res_sum", 32'(res_sum), 32'(msum));
            chk("rand_res_carry", 32'(res_carry), 32'(mcarry));
            chk("rand_res_id", 32'(res_id), 32'(mid));
        end
    endtask

    initial begin
        int g;
        bit [7:0] osum;

        vecs[0] = '{2, 8'h3C, 8'h05, 8'h41, 1'b0};
        vecs[1] = '{1, 8'hF0, 8'h20, SAT ? 8'hFF : 8'h10, 1'b1};
        vecs[2] = '{0, 8'hFF, 8'h01, SAT ? 8'hFF : 8'h00, 1'b1};
        vecs[3] = '{3, 8'h80, 8'h7F, 8'hFF, 1'b0};
        vecs[4] = '{0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{2, 8'hFF, 8'hFF, SAT ? 8'hFF : 8'hFE, 1'b1};

        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(res_valid), 0);
        chk("reset_sum", 32'(res_sum), 0);
        chk("reset_carry", 32'(res_carry), 0);
        chk("reset_id", 32'(res_id), 0);
        chk("reset_ready", 32'(req_ready), 0);
        rst_n = 1'b1;

        // Reset while a result is pending and backpressured
        req_valid = 4'b0010;
        set_op(1, 8'h11, 8'h22);
        tick();
        chk("midfull_valid", 32'(res_valid), 1);
        chk("midfull_id", 32'(res_id), 1);
        req_valid = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(res_valid), 0);
        chk("async_rst_sum", 32'(res_sum), 0);
        chk("async_rst_id", 32'(res_id), 0);
        #1 rst_n = 1'b1;
        tick();

        // Rotation with every requester valid
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 8'(i * 16 + 1), 8'(i));
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rot_ready", 32'(req_ready), 32'd1 << (k % NREQ));
            tick();
            chk("rot_valid", 32'(res_valid), 1);
            chk("rot_id", 32'(res_id), 32'(k % NREQ));
            chk("rot_sum", 32'(res_sum), 32'((k % NREQ) * 17 + 1));
        end
        req_valid = '0;
        tick();
        chk("rot_drain", 32'(res_valid), 0);

        // Backpressure
        req_valid = 4'b0100;
        set_op(2, 8'h3C, 8'h05);
        res_ready = 1'b0;
        tick();
        req_valid = 4'b0010;
        set_op(1, 8'h07, 8'h08);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 0);
            tick();
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_id", 32'(res_id), 2);
            chk("bp_sum", 32'(res_sum), 32'h41);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0010);
        tick();
        chk("bp_new_id", 32'(res_id), 1);
        chk("bp_new_sum", 32'(res_sum), 32'h0F);
        chk("bp_new_valid", 32'(res_valid), 1);
        req_valid = '0;
        tick();
        chk("bp_drain", 32'(res_valid), 0);
        chk("bp_hold_sum", 32'(res_sum), 32'h0F);

        // Pointer hold across idle cycles
        req_valid = 4'b1000;
        set_op(3, 8'h01, 8'h02);
        tick();
        chk("ph_id3", 32'(res_id), 3);
        req_valid = '0;
        repeat (5) tick();
        chk("ph_idle", 32'(res_valid), 0);
        req_valid = 4'b1001;
        set_op(0, 8'h05, 8'h06);
        #1;
        chk("ph_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("ph_id0", 32'(res_id), 0);
        req_valid = '0;
        tick();

        // Table-driven single-requester vectors
        for (int v = 0; v < 6; v++) begin
            req_valid = 4'(1 << vecs[v].id);
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            res_ready = 1'b1;
            tick();
            chk($sformatf("vec%0d_valid", v), 32'(res_valid), 1);
            chk($sformatf("vec%0d_sum", v), 32'(res_sum), 32'(vecs[v].exp_sum));
            chk($sformatf("vec%0d_carry", v), 32'(res_carry), 32'(vecs[v].exp_carry));
            chk($sformatf("vec%0d_id", v), 32'(res_id), 32'(vecs[v].id));
            osum = res_sum;
            req_valid = '0;
            tick();
            chk($sformatf("vec%0d_empty", v), 32'(res_valid), 0);
            chk($sformatf("vec%0d_hold", v), 32'(res_sum), 32'(osum));
        end

        // Randomised run against the model, starting from reset
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        mptr  = 0;
        mfull = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            vv[i] = 1'b0;
            wait_x[i] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!vv[i] && $urandom_range(0, 2) == 0) begin
                    vv[i] = 1'b1;
                    wait_x[i] = 0;
                    if ($urandom_range(0, 3) == 0) set_op(i, 8'hFF, 8'($urandom_range(0, 255)));
                    else set_op(i, 8'($urandom), 8'($urandom));
                end
                req_valid[i] = vv[i];
            end
            res_ready = ($urandom_range(0, 3) != 0);
            model_cycle(g);
            if (g >= 0) begin
                chk("fairness", 32'(wait_x[g] < NREQ), 1);
                vv[g] = 1'b0;
                for (int i = 0; i < NREQ; i++) if (vv[i]) wait_x[i]++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
